// File: rtl/sram_arbiter.sv
// Two-requester arbiter sharing one sram-like memory port between inst fetch and data access.
// Define ARB_RR_EN for round-robin arbitration instead of data priority with an inst starvation guard.
module sram_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inst_req,
  input  logic                inst_wr,
  input  logic [1:0]          inst_size,
  input  logic [ADDR_W-1:0]   inst_addr,
  input  logic [DATA_W/8-1:0] inst_wstrb,
  input  logic [DATA_W-1:0]   inst_wdata,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [1:0]          data_size,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                mem_req,
  output logic                mem_wr,
  output logic [1:0]          mem_size,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_addr_ok,
  input  logic                mem_data_ok,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  // state  | meaning
  // IDLE   | no transaction; arbitrate and accept a winner
  // ADDR   | mem_req asserted, waiting for mem_addr_ok
  // DATA   | request taken downstream, waiting for mem_data_ok
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  logic [1:0]          r_state;
  logic                r_grant_id;
  logic                r_mem_wr;
  logic [1:0]          r_mem_size;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W/8-1:0] r_mem_wstrb;
  logic [DATA_W-1:0]   r_mem_wdata;

  logic w_inst_win;
  logic w_accept;
  logic w_resp;
  logic w_in_data;

`ifdef ARB_RR_EN
  logic r_last_grant;

  // r_last_grant==1 means data won last time, so inst takes the next tie
  assign w_inst_win = inst_req && (!data_req || r_last_grant);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= 1'b1;
    end else if (w_accept) begin
      r_last_grant <= !w_inst_win;
    end
  end
`else
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] r_starve_cnt;

  assign w_inst_win = inst_req && (!data_req || r_starve_cnt == STARVE_LIM);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve_cnt <= 4'd0;
    end else if (w_accept) begin
      if (inst_req && !w_inst_win) begin
        r_starve_cnt <= (r_starve_cnt == STARVE_LIM) ? r_starve_cnt : r_starve_cnt + 4'd1;
      end else begin
        r_starve_cnt <= 4'd0;
      end
    end
  end
`endif

  // outputs are gated by rst so a reset cycle never accepts or completes anything
  assign w_accept  = (r_state == S_IDLE) && !rst && (inst_req || data_req);
  assign w_in_data = (r_state == S_DATA) && !rst;
  assign w_resp    = w_in_data && mem_data_ok;

  assign inst_addr_ok = w_accept && w_inst_win;
  assign data_addr_ok = w_accept && !w_inst_win;
  assign inst_data_ok = w_resp && !r_grant_id;
  assign data_data_ok = w_resp && r_grant_id;
  assign inst_rdata   = (w_in_data && !r_grant_id) ? mem_rdata : '0;
  assign data_rdata   = (w_in_data && r_grant_id) ? mem_rdata : '0;

  assign mem_req   = (r_state == S_ADDR);
  assign mem_wr    = r_mem_wr;
  assign mem_size  = r_mem_size;
  assign mem_addr  = r_mem_addr;
  assign mem_wstrb = r_mem_wstrb;
  assign mem_wdata = r_mem_wdata;
  assign busy      = (r_state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_grant_id  <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_size  <= 2'd0;
      r_mem_addr  <= '0;
      r_mem_wstrb <= '0;
      r_mem_wdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state     <= S_ADDR;
            r_grant_id  <= !w_inst_win;
            r_mem_wr    <= w_inst_win ? inst_wr    : data_wr;
            r_mem_size  <= w_inst_win ? inst_size  : data_size;
            r_mem_addr  <= w_inst_win ? inst_addr  : data_addr;
            r_mem_wstrb <= w_inst_win ? inst_wstrb : data_wstrb;
            r_mem_wdata <= w_inst_win ? inst_wdata : data_wdata;
          end
        end
        S_ADDR: begin
          if (mem_addr_ok) begin
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (mem_data_ok) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: expected grants, downstream fields and responses are queued
// by the stimulus and popped by independent monitors.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic [3:0]  inst_wstrb, data_wstrb;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        mem_addr_ok, mem_data_ok, busy;

  logic        rsp_aok, rsp_dok, man_aok, man_dok, resp_en;
  int          addr_dly;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          inst_aok_cyc = -1;
  int          data_dok_cyc = -1;

  typedef struct {
    logic        wr;
    logic [1:0]  sz;
    logic [31:0] a;
    logic [3:0]  st;
    logic [31:0] wd;
  } mreq_t;
  typedef struct {
    bit          id;
    logic [31:0] rd;
  } resp_t;

  int    grant_q[$];
  mreq_t mem_q[$];
  resp_t resp_q[$];

  assign mem_addr_ok = rsp_aok | man_aok;
  assign mem_data_ok = rsp_dok | man_dok;

  sram_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    return (a == 32'hBFC0_0000) ? 32'h3C1D_0000 : (a ^ 32'h5A5A_5A5A);
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic push_exp(input bit id, input logic wr, input logic [1:0] sz,
                          input logic [31:0] a, input logic [3:0] st, input logic [31:0] wd);
    grant_q.push_back(int'(id));
    mem_q.push_back('{wr, sz, a, st, wd});
    resp_q.push_back('{id, rd_model(a)});
  endtask

  task automatic inst_xact(input logic wr, input logic [1:0] sz, input logic [31:0] a,
                           input logic [3:0] st, input logic [31:0] wd);
    int n;
    inst_wr = wr; inst_size = sz; inst_addr = a; inst_wstrb = st; inst_wdata = wd;
    inst_req = 1'b1;
    n = 0;
    @(negedge clk);
    while (!inst_addr_ok && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!inst_addr_ok) chk("inst_accept_timeout", 0, 1);
    @(posedge clk); #1;
    inst_req = 1'b0;
  endtask

  task automatic data_xact(input logic wr, input logic [1:0] sz, input logic [31:0] a,
                           input logic [3:0] st, input logic [31:0] wd);
    int n;
    data_wr = wr; data_size = sz; data_addr = a; data_wstrb = st; data_wdata = wd;
    data_req = 1'b1;
    n = 0;
    @(negedge clk);
    while (!data_addr_ok && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!data_addr_ok) chk("data_accept_timeout", 0, 1);
    @(posedge clk); #1;
    data_req = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((resp_q.size() != 0 || grant_q.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("grant_queue_empty", 128'(grant_q.size()), 0);
    chk("resp_queue_empty", 128'(resp_q.size()), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // downstream memory model: accepts after addr_dly cycles, responds the cycle after
  initial begin
    rsp_aok = 1'b0; rsp_dok = 1'b0; mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (resp_en && mem_req) begin
        repeat (addr_dly) begin @(posedge clk); #1; end
        rsp_aok = 1'b1;
        if (mem_q.size() == 0) begin
          chk("mem_unexpected_req", 1, 0);
        end else begin
          mreq_t e;
          e = mem_q.pop_front();
          chk("mem_fields", {mem_wr, mem_size, mem_addr, mem_wstrb, mem_wdata},
              {e.wr, e.sz, e.a, e.st, e.wd});
        end
        @(posedge clk); #1;
        rsp_aok = 1'b0;
        rsp_dok = 1'b1;
        mem_rdata = rd_model(mem_addr);
        @(posedge clk); #1;
        rsp_dok = 1'b0;
        mem_rdata = '0;
      end
    end
  end

  // upstream monitor: grant order and response scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (inst_addr_ok && data_addr_ok) chk("double_grant", 1, 0);
      else if (inst_addr_ok || data_addr_ok) begin
        if (inst_addr_ok) inst_aok_cyc = cyc;
        if (grant_q.size() == 0) chk("unexpected_grant", 1, 0);
        else chk("grant_id", {127'd0, data_addr_ok}, 128'(grant_q.pop_front()));
      end
      if (inst_data_ok && data_data_ok) chk("double_resp", 1, 0);
      else if (inst_data_ok || data_data_ok) begin
        if (data_data_ok) data_dok_cyc = cyc;
        if (resp_q.size() == 0) chk("unexpected_resp", 1, 0);
        else begin
          resp_t r;
          r = resp_q.pop_front();
          chk("resp_id", {127'd0, data_data_ok}, {127'd0, r.id});
          chk("resp_rdata", data_data_ok ? data_rdata : inst_rdata, r.rd);
          chk("other_rdata_zero", data_data_ok ? inst_rdata : data_rdata, 0);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got running expected finished");
    $fatal(1, "timeout");
  end

  logic [0:9] order;
  int ii, di;

  initial begin
    rst = 1'b1; resp_en = 1'b1; addr_dly = 0; man_aok = 1'b0; man_dok = 1'b0;
    inst_req = 1'b1; inst_wr = 1'b0; inst_size = 2'd2; inst_addr = 32'h1234_5678;
    inst_wstrb = 4'hF; inst_wdata = '0;
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'd2; data_addr = '0;
    data_wstrb = '0; data_wdata = '0;

    // reset state, with inst_req held to show no acceptance during reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_inst_addr_ok", inst_addr_ok, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_fields", {mem_wr, mem_size, mem_addr, mem_wstrb, mem_wdata}, 0);
    chk("rst_rdata", {inst_rdata, data_rdata}, 0);
    @(posedge clk); #1;
    inst_req = 1'b0; rst = 1'b0;
    @(posedge clk); #1;

    // single inst read with a slow downstream accept
    addr_dly = 2;
    push_exp(1'b0, 1'b0, 2'd2, 32'hBFC0_0000, 4'hF, 32'h0);
    fork
      inst_xact(1'b0, 2'd2, 32'hBFC0_0000, 4'hF, 32'h0);
      begin
        int n = 0;
        @(negedge clk);
        while (!inst_addr_ok && n < 50) begin @(negedge clk); n++; end
        chk("t1_busy_c0", busy, 0);
        for (int k = 1; k <= 5; k++) begin
          @(negedge clk);
          chk($sformatf("t1_mem_req_c%0d", k), mem_req, (k <= 3) ? 1 : 0);
          chk($sformatf("t1_busy_c%0d", k), busy, (k <= 4) ? 1 : 0);
          if (k == 4) chk("t1_inst_data_ok_c4", inst_data_ok, 1);
        end
      end
    join
    drain();
    addr_dly = 0;

    // simultaneous inst read and data word store: data first
    push_exp(1'b1, 1'b1, 2'd2, 32'h8000_1000, 4'hF, 32'h1234_5678);
    push_exp(1'b0, 1'b0, 2'd2, 32'hBFC0_0004, 4'hF, 32'h0);
    fork
      inst_xact(1'b0, 2'd2, 32'hBFC0_0004, 4'hF, 32'h0);
      data_xact(1'b1, 2'd2, 32'h8000_1000, 4'hF, 32'h1234_5678);
    join
    drain();
    chk("t2_inst_accept_after_data_ok", 128'(inst_aok_cyc - data_dok_cyc), 1);

    // spurious downstream responses while idle
    man_aok = 1'b1;
    @(negedge clk);
    chk("spur_aok_no_pulse", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, busy}, 0);
    @(posedge clk); #1;
    man_aok = 1'b0; man_dok = 1'b1;
    @(negedge clk);
    chk("spur_dok_no_pulse", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, busy}, 0);
    @(posedge clk); #1;
    man_dok = 1'b0;
    @(negedge clk);
    chk("spur_still_idle", {busy, mem_req}, 0);
    @(posedge clk); #1;

    // reset while in DATA drops the transaction
    resp_en = 1'b0;
    grant_q.push_back(0);
    fork
      inst_xact(1'b0, 2'd2, 32'hBFC0_0200, 4'hF, 32'h0);
      begin
        int n = 0;
        @(negedge clk);
        while (!mem_req && n < 50) begin @(negedge clk); n++; end
        chk("rstx_mem_req_seen", mem_req, 1);
        @(posedge clk); #1;
        man_aok = 1'b1;
        @(posedge clk); #1;
        man_aok = 1'b0;
        @(negedge clk);
        chk("rstx_in_data", {busy, mem_req}, 2'b10);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; man_dok = 1'b1;
        @(negedge clk);
        chk("rstx_after", {busy, mem_req, inst_data_ok, data_data_ok}, 0);
        @(posedge clk); #1;
        man_dok = 1'b0;
      end
    join
    resp_en = 1'b1;
    push_exp(1'b0, 1'b0, 2'd2, 32'hBFC0_0300, 4'hF, 32'h0);
    inst_xact(1'b0, 2'd2, 32'hBFC0_0300, 4'hF, 32'h0);
    drain();

    // both held: 2 inst and 8 data transactions, starting from a fresh reset
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
`ifdef ARB_RR_EN
    order = 10'b0101111111;
`else
    order = 10'b1111011110;
`endif
    ii = 0; di = 0;
    for (int k = 0; k < 10; k++) begin
      if (order[k]) begin
        push_exp(1'b1, di[0], 2'd2, 32'h8000_2000 + 32'(4 * di), 4'hF, 32'hD000_0000 + 32'(di));
        di++;
      end else begin
        push_exp(1'b0, 1'b0, 2'd2, 32'hBFC0_0100 + 32'(4 * ii), 4'hF, 32'h0);
        ii++;
      end
    end
    fork
      for (int k = 0; k < 2; k++)
        inst_xact(1'b0, 2'd2, 32'hBFC0_0100 + 32'(4 * k), 4'hF, 32'h0);
      for (int k = 0; k < 8; k++)
        data_xact(k[0], 2'd2, 32'h8000_2000 + 32'(4 * k), 4'hF, 32'hD000_0000 + 32'(k));
    join
    drain();
    chk("mem_queue_empty", 128'(mem_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Two-requester arbiter that shares one downstream sram-like memory port between the core's instruction-fetch and data-access interfaces.
- Sits between the core's (already address-translated) inst/data request ports and the single memory/bridge port.
- Runs a 3-state FSM and allows at most one outstanding transaction.
- Fixed data-over-inst priority, with a starvation guard for inst.

Parameters:
- ADDR_W, 32, address width on all ports.
- DATA_W, 32, data width on all ports.
- STARVE_MAX, 4, consecutive lost arbitrations after which a waiting inst request is forced to win; range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- inst_req  in  1  inst request valid, held until inst_addr_ok
- inst_wr  in  1  1=write
- inst_size  in  2  0=byte,1=half,2=word
- inst_addr  in  ADDR_W  request address
- inst_wstrb  in  DATA_W/8  byte enables
- inst_wdata  in  DATA_W  write data
- inst_addr_ok  out  1  request accepted (1-cycle pulse)
- inst_data_ok  out  1  response valid (1-cycle pulse)
- inst_rdata  out  DATA_W  read data, valid with inst_data_ok
- data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata, data_addr_ok, data_data_ok, data_rdata: same widths, directions and meaning as the inst_* ports.
- mem_req  out  1  downstream request valid
- mem_wr, mem_size, mem_addr, mem_wstrb, mem_wdata  out  as above  latched request fields
- mem_addr_ok  in  1  downstream accepted request
- mem_data_ok  in  1  downstream response valid
- mem_rdata  in  DATA_W  downstream read data
- busy  out  1  FSM not in IDLE

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - rst synchronous, active-high; all state updates on posedge clk.
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - If no request is pending, stay in IDLE.
  - Otherwise pick a winner: data beats inst, unless starve_cnt==STARVE_MAX and inst_req=1, in which case inst wins.
  - In the same cycle, combinationally pulse the winner's *_addr_ok.
  - Latch the winner's wr/size/addr/wstrb/wdata into the mem_* registers and record grant_id (0=inst, 1=data).
  - Next state: ADDR.
  - The loser sees no addr_ok and keeps holding its request.
- ADDR:
  - mem_req=1, driven from the latched registers.
  - On mem_addr_ok=1, next state is DATA and mem_req drops the following cycle.
  - No new upstream acceptance while in ADDR.
- DATA:
  - mem_req=0.
  - On mem_data_ok=1, pulse the grant_id requester's *_data_ok in the same cycle (combinational).
  - The granted requester's *_rdata = mem_rdata; the non-granted *_rdata = 0.
  - Next state: IDLE.
- Throughput and latency:
  - Minimum transaction is 3 cycles: accept in cycle 0, mem_req in cycle 1, data_ok in cycle 2 when the memory responds immediately.
  - A new accept is possible in the cycle after data_ok.
- starve_cnt (4-bit) updates only on IDLE accept cycles:
  - Increments when inst_req=1 and data wins.
  - Clears when inst wins or inst_req=0.
  - Saturates at STARVE_MAX.
- Spurious responses: mem_data_ok in IDLE/ADDR and mem_addr_ok in IDLE/DATA are ignored; no upstream pulse results.
- Reset values:
  - State IDLE, mem_req=0, all mem_* registers 0, grant_id=0, starve_cnt=0.
  - All *_addr_ok/*_data_ok 0, all *_rdata 0, busy=0.
- Reset mid-transaction:
  - Next cycle is IDLE with outputs at reset values; the outstanding transaction is dropped with no data_ok.
  - The downstream port shares the same reset.
- Write transactions complete exactly like reads: data_ok on mem_data_ok; rdata is don't-care but driven from mem_rdata.

Optional Feature:
- Macro: ARB_RR_EN.
- Defined:
  - Round-robin arbitration. On a simultaneous request, the requester not granted last time wins.
  - last_grant register, reset to 1 so inst wins the first tie.
  - starve_cnt is not instantiated; STARVE_MAX is unused.
- Undefined: fixed data-priority with the starvation guard as described under Behaviour.

Test Plan:
- Single inst read to 0xBFC00000; mem_addr_ok 2 cycles after mem_req; mem_data_ok next cycle with mem_rdata=0x3C1D0000 -> required response:
  - inst_addr_ok pulse at cycle 0.
  - mem_req high cycles 1-3 with mem_addr=0xBFC00000, mem_wr=0.
  - inst_data_ok with inst_rdata=0x3C1D0000 at cycle 4.
  - busy high cycles 1-4.
- Simultaneous inst read 0xBFC00004 and data word store 0x80001000/wstrb 0xF/wdata 0x12345678 -> required response:
  - data_addr_ok first; mem_wr=1 with those fields.
  - inst_addr_ok only in the cycle after data_data_ok; then mem_addr=0xBFC00004.
- STARVE_MAX=4; data_req held high continuously with inst_req held high -> required response: data granted 4 times, then inst granted on the 5th accept, then data resumes.
- mem_data_ok and mem_addr_ok pulsed while IDLE with no requests -> required response: no *_addr_ok or *_data_ok pulses; state stays IDLE.
- rst asserted for 1 cycle while in DATA state -> required response:
  - Next cycle: mem_req=0, busy=0, no data_ok.
  - Subsequent inst read completes normally.
- ARB_RR_EN defined; both requesters held high for 4 transactions -> required grant order: inst, data, inst, data.
